// File: rtl/dma_pkg.sv
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the DMA descriptor fetch engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_RESP     = 2'd2,
        ST_DISPATCH = 2'd3
    } state_e;

    localparam logic [3:0] SRC_OFS = 4'd0;
    localparam logic [3:0] DST_OFS = 4'd4;
    localparam logic [3:0] LEN_OFS = 4'd8;
    localparam logic [3:0] NXT_OFS = 4'd12;

    // Descriptor words as they come back from the 32-bit read data bus.
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [31:0] next;
    } desc_t;

    function automatic logic [3:0] word_ofs(input logic [1:0] idx);
        logic [3:0] ofs;
        case (idx)
            2'd0:    ofs = SRC_OFS;
            2'd1:    ofs = DST_OFS;
            2'd2:    ofs = LEN_OFS;
            default: ofs = NXT_OFS;
        endcase
        return ofs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_desc_fetch.sv
// ============================================================================
// Module      : dma_desc_fetch
// Description : Walks a linked list of 4-word descriptors over a single-
//               outstanding read master and hands each to the transfer engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_desc_fetch
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ctrl_go_i,
    input  logic [ADDR_W-1:0] desc_ptr_i,
    output logic              rd_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_wait_rq_i,
    input  logic              rd_data_valid_i,
    input  logic [31:0]       rd_data_i,
    output logic              desc_valid_o,
    input  logic              desc_ready_i,
    output logic [ADDR_W-1:0] desc_src_o,
    output logic [ADDR_W-1:0] desc_dst_o,
    output logic [31:0]       desc_len_o,
    output logic              desc_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  desc_cnt_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    desc_t             desc_q, desc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              go_q;
    logic              go_rise;
    logic              next_zero;

    assign go_rise   = ctrl_go_i & ~go_q;
    assign next_zero = (desc_q.next == 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            desc_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            desc_q  <= desc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            go_q    <= ctrl_go_i;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        desc_d  = desc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_rise) begin
                    ptr_d = desc_ptr_i;
                    err_d = 1'b0;
                    cnt_d = '0;
                    idx_d = 2'd0;
                    // A bad start pointer finishes the chain without any read.
                    if ((desc_ptr_i[1:0] != 2'b00) || (desc_ptr_i == '0)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (!rd_wait_rq_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rd_data_valid_i) begin
                    case (idx_q)
                        2'd0:    desc_d.src  = rd_data_i;
                        2'd1:    desc_d.dst  = rd_data_i;
                        2'd2:    desc_d.len  = rd_data_i;
                        default: desc_d.next = rd_data_i;
                    endcase
                    if (idx_q == 2'd3) begin
                        state_d = ST_DISPATCH;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DISPATCH: begin
                if (desc_ready_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Abort is only honoured here, after the descriptor is out.
                    if (next_zero || !ctrl_go_i) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (desc_q.next[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d   = ADDR_W'(desc_q.next);
                        idx_d   = 2'd0;
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_o         = (state_q == ST_REQ);
    assign rd_addr_o    = rd_o ? (ptr_q + ADDR_W'(word_ofs(idx_q))) : '0;
    assign desc_valid_o = (state_q == ST_DISPATCH);
    assign desc_src_o   = ADDR_W'(desc_q.src);
    assign desc_dst_o   = ADDR_W'(desc_q.dst);
    assign desc_len_o   = desc_q.len;
    assign desc_last_o  = desc_valid_o & next_zero;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign desc_cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_desc_fetch.sv
// ============================================================================
// Module      : tb_dma_desc_fetch
// Description : Directed bench for dma_desc_fetch with a memory/slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_desc_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ctrl_go_i;
    logic [31:0] desc_ptr_i;
    logic        rd_o;
    logic [31:0] rd_addr_o;
    logic        rd_wait_rq_i;
    logic        rd_data_valid_i;
    logic [31:0] rd_data_i;
    logic        desc_valid_o;
    logic        desc_ready_i;
    logic [31:0] desc_src_o;
    logic [31:0] desc_dst_o;
    logic [31:0] desc_len_o;
    logic        desc_last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] desc_cnt_o;

    dma_desc_fetch #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ctrl_go_i       (ctrl_go_i),
        .desc_ptr_i      (desc_ptr_i),
        .rd_o            (rd_o),
        .rd_addr_o       (rd_addr_o),
        .rd_wait_rq_i    (rd_wait_rq_i),
        .rd_data_valid_i (rd_data_valid_i),
        .rd_data_i       (rd_data_i),
        .desc_valid_o    (desc_valid_o),
        .desc_ready_i    (desc_ready_i),
        .desc_src_o      (desc_src_o),
        .desc_dst_o      (desc_dst_o),
        .desc_len_o      (desc_len_o),
        .desc_last_o     (desc_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .desc_cnt_o      (desc_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];

    int          wait_cfg   = 0;
    bit          slave_hold = 1'b0;
    bit          slave_clr  = 1'b0;
    bit          stray      = 1'b0;
    bit          resp_pend  = 1'b0;
    logic [31:0] resp_addr  = '0;
    bit          stalling   = 1'b0;
    int          waits_left = 0;
    logic [31:0] stall_addr = '0;

    typedef struct {
        logic [31:0] ptr;
        int          wt;
        int          rdy;
        int          exp_cnt;
        bit          exp_err;
        int          exp_reads;
        logic [31:0] abrt;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] l, input logic [31:0] n);
        mem[a] = s; mem[a + 4] = d; mem[a + 8] = l; mem[a + 12] = n;
    endtask

    // Read slave: programmable wait states, data one cycle after acceptance.
    always @(negedge clk) begin
        rd_data_valid_i = 1'b0;
        rd_wait_rq_i    = 1'b0;
        if (slave_clr) begin
            resp_pend = 1'b0;
            stalling  = 1'b0;
        end
        if (resp_pend && !slave_hold) begin
            rd_data_valid_i = 1'b1;
            rd_data_i       = mem_rd(resp_addr);
            resp_pend       = 1'b0;
        end
        if (stray) begin
            rd_data_valid_i = 1'b1;
            rd_data_i       = 32'hDEADBEEF;
        end
        if (rd_o && reset_n) begin
            if (!stalling) begin
                stalling   = 1'b1;
                waits_left = wait_cfg;
                stall_addr = rd_addr_o;
            end else begin
                chk("addr_stable_under_stall", rd_addr_o, stall_addr);
            end
            if (waits_left > 0) begin
                rd_wait_rq_i = 1'b1;
                waits_left--;
            end else begin
                stalling  = 1'b0;
                resp_pend = 1'b1;
                resp_addr = rd_addr_o;
                rd_log.push_back(rd_addr_o);
            end
        end
    end

    task automatic run_chain(input vec_t v, input int vi);
        logic [31:0] exp_addr [$];
        logic [31:0] p;
        logic [31:0] s_src, s_dst, s_len;
        int base, dones, vcnt, hold;
        p = v.ptr;
        for (int d = 0; d < v.exp_reads / 4; d++) begin
            for (int w = 0; w < 4; w++) exp_addr.push_back(p + 32'(4 * w));
            p = mem_rd(p + 12);
        end
        @(negedge clk); #1 wait_cfg = v.wt;
        @(negedge clk);
        base = rd_log.size();
        desc_ptr_i = v.ptr; ctrl_go_i = 1'b1; desc_ready_i = 1'b0;
        p = v.ptr; dones = 0; vcnt = 0; hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            desc_ready_i = 1'b0;
            if (c == 0) chk("busy_after_go", busy_o, v.exp_reads > 0);
            if (v.abrt != 0 && rd_o && rd_addr_o == v.abrt) ctrl_go_i = 1'b0;
            if (desc_valid_o) begin
                vcnt++;
                if (vcnt == 1) begin
                    s_src = desc_src_o; s_dst = desc_dst_o; s_len = desc_len_o;
                end else begin
                    chk("src_stable", desc_src_o, s_src);
                    chk("dst_stable", desc_dst_o, s_dst);
                    chk("len_stable", desc_len_o, s_len);
                end
                if (vcnt > v.rdy) begin
                    chk("desc_src", desc_src_o, mem_rd(p));
                    chk("desc_dst", desc_dst_o, mem_rd(p + 4));
                    chk("desc_len", desc_len_o, mem_rd(p + 8));
                    chk("desc_last", desc_last_o, mem_rd(p + 12) == 0);
                    p = mem_rd(p + 12);
                    vcnt = 0;
                    desc_ready_i = 1'b1;
                end
            end
            if (done_o) begin
                dones++;
                chk("busy_at_done", busy_o, 1'b0);
            end
            if (dones > 0) begin
                hold++;
                if (hold > 3) break;
            end
        end
        chk($sformatf("v%0d_done_count", vi), dones, 1);
        chk($sformatf("v%0d_desc_cnt", vi), desc_cnt_o, v.exp_cnt);
        chk($sformatf("v%0d_err", vi), err_o, v.exp_err);
        chk($sformatf("v%0d_read_count", vi), rd_log.size() - base, v.exp_reads);
        for (int i = 0; i < exp_addr.size() && base + i < rd_log.size(); i++)
            chk($sformatf("v%0d_read_addr%0d", vi, i), rd_log[base + i], exp_addr[i]);
        ctrl_go_i = 1'b0; desc_ready_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd"},    rd_o, 1'b0);
        chk({tag, "_addr"},  rd_addr_o, 32'h0);
        chk({tag, "_valid"}, desc_valid_o, 1'b0);
        chk({tag, "_src"},   desc_src_o, 32'h0);
        chk({tag, "_dst"},   desc_dst_o, 32'h0);
        chk({tag, "_len"},   desc_len_o, 32'h0);
        chk({tag, "_last"},  desc_last_o, 1'b0);
        chk({tag, "_busy"},  busy_o, 1'b0);
        chk({tag, "_done"},  done_o, 1'b0);
        chk({tag, "_err"},   err_o, 1'b0);
        chk({tag, "_cnt"},   desc_cnt_o, 16'h0);
    endtask

    vec_t vecs [8];
    int   ncyc;

    initial begin
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd64,   32'h0);
        put_desc(32'h400, 32'h1400, 32'h2400, 32'h80,   32'h500);
        put_desc(32'h500, 32'h1500, 32'h2500, 32'h100,  32'h600);
        put_desc(32'h600, 32'h1600, 32'h2600, 32'h0,    32'h0);
        put_desc(32'h800, 32'h3000, 32'h4000, 32'h20,   32'h206);

        //          ptr       wt rdy cnt err reads abort
        vecs[0] = '{32'h100,  0, 0,  1,  0,  4,  32'h0};
        vecs[1] = '{32'h400,  3, 5,  3,  0,  12, 32'h0};
        vecs[2] = '{32'h102,  0, 0,  0,  1,  0,  32'h0};
        vecs[3] = '{32'h100,  1, 2,  1,  0,  4,  32'h0};
        vecs[4] = '{32'h800,  0, 0,  1,  1,  4,  32'h0};
        vecs[5] = '{32'h000,  0, 0,  0,  1,  0,  32'h0};
        vecs[6] = '{32'h400,  0, 0,  3,  0,  12, 32'h0};
        vecs[7] = '{32'h400,  0, 0,  2,  0,  8,  32'h504};

        reset_n = 1'b0; ctrl_go_i = 1'b0; desc_ptr_i = '0; desc_ready_i = 1'b0;
        rd_data_i = '0; rd_wait_rq_i = 1'b0; rd_data_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Minimum latency: GO edge to handshake in nine cycles.
        desc_ptr_i = 32'h100; ctrl_go_i = 1'b1; desc_ready_i = 1'b1;
        ncyc = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            ncyc++;
            if (ncyc == 1) begin
                chk("lat_rd_first", rd_o, 1'b1);
                chk("lat_addr_first", rd_addr_o, 32'h100);
                chk("lat_busy_first", busy_o, 1'b1);
            end
            if (desc_valid_o) break;
        end
        chk("lat_cycles_to_handshake", ncyc, 9);
        @(negedge clk);
        chk("lat_done", done_o, 1'b1);
        chk("lat_busy_low_at_done", busy_o, 1'b0);
        chk("lat_cnt", desc_cnt_o, 16'd1);
        ctrl_go_i = 1'b0; desc_ready_i = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_chain(vecs[i], i);
            repeat (2) @(negedge clk);
        end

        // Reset while waiting for read data, then a stray return strobe.
        #1 slave_hold = 1'b1; wait_cfg = 0;
        @(negedge clk);
        desc_ptr_i = 32'h100; ctrl_go_i = 1'b1;
        ncyc = rd_log.size();
        for (int c = 0; c < 50 && rd_log.size() == ncyc; c++) @(negedge clk);
        chk("rst_read_issued", rd_log.size(), ncyc + 1);
        @(negedge clk);
        chk("rst_busy_in_resp", busy_o, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_idle("midreset");
        slave_clr = 1'b1; ctrl_go_i = 1'b0;
        @(negedge clk); #1;
        slave_clr = 1'b0; slave_hold = 1'b0; reset_n = 1'b1; stray = 1'b1;
        @(negedge clk); #1;
        stray = 1'b0;
        @(negedge clk);
        chk_idle("stray");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
